// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    KILL
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus: level-held request, one-cycle response strobe.
interface if_stage_if;

  logic        im_req;
  logic [31:0] im_addr;
  logic        im_rvalid;
  logic [31:0] im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_rvalid,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_rvalid,
    output im_rdata
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// Parks one fetched instruction and its PC while decode is stalled.
module fetch_hold_buf #(
  parameter logic [31:0] RstPc   = cpu_pkg::RESET_PC,
  parameter logic [31:0] RstInst = cpu_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    inst_d = inst_q;
    pc_d   = pc_q;
    if (clear_i) begin
      inst_d = RstInst;
      pc_d   = RstPc;
    end else if (load_i) begin
      inst_d = inst_i;
      pc_d   = pc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q <= RstInst;
      pc_q   <= RstPc;
    end else begin
      inst_q <= inst_d;
      pc_q   <= pc_d;
    end
  end

  assign inst_o = inst_q;
  assign pc_o   = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, one outstanding imem request,
// absorbs stalls and jump/branch redirects, presents {pc, inst, valid} to decode.
module if_stage #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               mul_stall,
  input  logic               jb,
  input  logic [31:0]        jb_target,
  if_stage_if.master         imem,
  output logic [31:0]        pc_out,
  output logic [31:0]        inst_out,
  output logic               inst_valid
);

  import cpu_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  redirect_pc_q, redirect_pc_d;
  logic         buf_load, buf_clear;
  logic [31:0]  buf_inst, buf_pc;
  logic         hold;
  logic [31:0]  jb_tgt;

  assign hold   = stall | mul_stall;
  assign jb_tgt = jb_target & ~32'h3;

  assign imem.im_req  = (state_q != HOLD) && !rst;
  assign imem.im_addr = fetch_pc_q;

  fetch_hold_buf #(
    .RstPc   (RESET_PC),
    .RstInst (NOP_INST)
  ) u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .inst_i  (imem.im_rdata),
    .pc_i    (fetch_pc_q),
    .inst_o  (buf_inst),
    .pc_o    (buf_pc)
  );

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;
    inst_valid    = 1'b0;
    inst_out      = NOP_INST;
    pc_out        = fetch_pc_q;

    unique case (state_q)
      FETCH: begin
        if (jb) begin
          if (imem.im_rvalid) begin
            fetch_pc_d = jb_tgt;
          end else begin
            redirect_pc_d = jb_tgt;
            state_d       = KILL;
          end
        end else if (imem.im_rvalid) begin
          if (hold) begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end else begin
            inst_valid = 1'b1;
            inst_out   = imem.im_rdata;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
      end
      HOLD: begin
        pc_out = buf_pc;
        if (jb) begin
          buf_clear  = 1'b1;
          fetch_pc_d = jb_tgt;
          state_d    = FETCH;
        end else if (!hold) begin
          inst_valid = 1'b1;
          inst_out   = buf_inst;
          fetch_pc_d = buf_pc + 32'd4;
          state_d    = FETCH;
        end
      end
      KILL: begin
        // Wrong-path request still in flight; only its completion frees the bus.
        if (jb) begin
          redirect_pc_d = jb_tgt;
          if (imem.im_rvalid) begin
            fetch_pc_d = jb_tgt;
            state_d    = FETCH;
          end
        end else if (imem.im_rvalid) begin
          fetch_pc_d = redirect_pc_q;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    if (rst) begin
      inst_valid = 1'b0;
      inst_out   = NOP_INST;
      pc_out     = RESET_PC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= RESET_PC;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Cycle-by-cycle vector bench for if_stage with an expected-output scoreboard.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        mul;
    logic        jb;
    logic [31:0] tgt;
    logic        rv;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        mul_stall = 1'b0;
  logic        jb = 1'b0;
  logic [31:0] jb_target = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid;

  int n_checks = 0;
  int n_err    = 0;

  vec_t tbl[$];
  vec_t exp_q[$];

  if_stage_if imem ();

  if_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .mul_stall  (mul_stall),
    .jb         (jb),
    .jb_target  (jb_target),
    .imem       (imem),
    .pc_out     (pc_out),
    .inst_out   (inst_out),
    .inst_valid (inst_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  function automatic vec_t mk(logic r, logic s, logic m, logic j, logic [31:0] t, logic v,
                              logic ereq, logic [31:0] eaddr, logic eval, logic [31:0] epc);
    vec_t x;
    x.rst = r; x.stall = s; x.mul = m; x.jb = j; x.tgt = t; x.rv = v;
    x.e_req = ereq; x.e_addr = eaddr; x.e_valid = eval; x.e_pc = epc;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare mid-cycle.
  task automatic step(string tag, vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    rst             = v.rst;
    stall           = v.stall;
    mul_stall       = v.mul;
    jb              = v.jb;
    jb_target       = v.tgt;
    imem.im_rvalid  = v.rv;
    imem.im_rdata   = v.rv ? (v.e_addr ^ KEY) : 32'hDEAD_BEEF;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, " im_req"}, {31'b0, imem.im_req}, {31'b0, e.e_req});
    if (e.e_req) chk({tag, " im_addr"}, imem.im_addr, e.e_addr);
    chk({tag, " inst_valid"}, {31'b0, inst_valid}, {31'b0, e.e_valid});
    chk({tag, " inst_out"}, inst_out, e.e_valid ? (e.e_pc ^ KEY) : NOP);
    chk({tag, " pc_out"}, pc_out, e.e_pc);
  endtask

  initial begin
    imem.im_rvalid = 1'b0;
    imem.im_rdata  = 32'h0;

    //             rst s m jb tgt           rv req addr          val pc
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       1, 1, 32'h0,       1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       1, 1, 32'h4,       1, 32'h4));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,       1, 1, 32'h8,       0, 32'h8));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,       0, 0, 32'h8,       0, 32'h8));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,       1, 0, 32'h8,       0, 32'h8));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,       0, 0, 32'h8,       0, 32'h8));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       0, 0, 32'h8,       1, 32'h8));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       0, 1, 32'hC,       0, 32'hC));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       1, 1, 32'hC,       1, 32'hC));
    tbl.push_back(mk(0, 0, 0, 1, 32'h103,     0, 1, 32'h10,      0, 32'h10));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       0, 1, 32'h10,      0, 32'h10));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       1, 1, 32'h10,      0, 32'h10));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       0, 1, 32'h100,     0, 32'h100));
    tbl.push_back(mk(0, 0, 0, 1, 32'h200,     1, 1, 32'h100,     0, 32'h100));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       1, 1, 32'h200,     1, 32'h200));
    tbl.push_back(mk(0, 0, 0, 1, 32'h300,     0, 1, 32'h204,     0, 32'h204));
    tbl.push_back(mk(0, 0, 0, 1, 32'h400,     0, 1, 32'h204,     0, 32'h204));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       1, 1, 32'h204,     0, 32'h204));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       1, 1, 32'h400,     1, 32'h400));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,       1, 1, 32'h404,     0, 32'h404));
    tbl.push_back(mk(0, 1, 0, 1, 32'h500,     0, 0, 32'h404,     0, 32'h404));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       1, 1, 32'h500,     1, 32'h500));
    tbl.push_back(mk(0, 0, 0, 1, 32'h600,     0, 1, 32'h504,     0, 32'h504));
    tbl.push_back(mk(0, 0, 0, 1, 32'h700,     1, 1, 32'h504,     0, 32'h504));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       1, 1, 32'h700,     1, 32'h700));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,       1, 1, 32'h704,     0, 32'h704));
    tbl.push_back(mk(0, 0, 0, 1, 32'h800,     0, 0, 32'h704,     0, 32'h704));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       1, 1, 32'h800,     1, 32'h800));

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("row%0d", i), tbl[i]);
    end

    // PC wrap: misaligned target lands on the last word, then increments to 0.
    step("wrap0", mk(0, 0, 0, 1, 32'hFFFF_FFFE, 1, 1, 32'h804,       0, 32'h804));
    step("wrap1", mk(0, 0, 0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC));
    step("wrap2", mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h0,         0, 32'h0));

    // Reset while a killed request is outstanding abandons the pending redirect.
    step("rst0", mk(0, 0, 0, 1, 32'h900, 0, 1, 32'h0, 0, 32'h0));
    step("rst1", mk(1, 0, 0, 0, 32'h0,   1, 0, 32'h0, 0, 32'h0));
    step("rst2", mk(0, 0, 0, 0, 32'h0,   0, 1, 32'h0, 0, 32'h0));
    step("rst3", mk(0, 0, 0, 0, 32'h0,   1, 1, 32'h0, 1, 32'h0));
    step("rst4", mk(0, 0, 0, 0, 32'h0,   1, 1, 32'h4, 1, 32'h4));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
